// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a multi-cycle instruction memory
// through a req/done handshake and presents fetched instructions to IF/ID.
module fetch_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        imem_done,
   output logic [15:0] instruction_out,
   output logic [15:0] PC_NO_PLUS_TWO_OUT,
   output logic [15:0] PC_next_out,
   output logic        if_valid,
   output logic        halt_fetched
);

   typedef enum logic [1:0] {
      ST_REQ,
      ST_WAIT,
      ST_PRESENT,
      ST_HALTED
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ibuf_q, ibuf_d;
   logic        kill_q, kill_d;
   logic [15:0] pc_plus2;
   logic        is_halt;

   assign pc_plus2 = pc_q + 16'd2;
   assign is_halt  = (ibuf_q[15:11] == 5'b00000);

   assign PC_NO_PLUS_TWO_OUT = pc_q;
   assign PC_next_out        = pc_plus2;

   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      ibuf_d          = ibuf_q;
      kill_d          = kill_q;
      imem_req        = 1'b0;
      imem_addr       = pc_q;
      if_valid        = 1'b0;
      instruction_out = NOP_INSTR;
      halt_fetched    = 1'b0;

      unique case (state_q)
         ST_REQ: begin
            imem_req = 1'b1;
            state_d  = ST_WAIT;
            // The request already went out; its response must be dropped.
            if (redirect) begin
               pc_d   = redirect_pc;
               kill_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (imem_done) begin
               if (kill_q || redirect) begin
                  kill_d  = 1'b0;
                  state_d = ST_REQ;
                  if (redirect) pc_d = redirect_pc;
               end else begin
                  ibuf_d  = imem_rdata;
                  state_d = ST_PRESENT;
               end
            end else if (redirect) begin
               pc_d   = redirect_pc;
               kill_d = 1'b1;
            end
         end
         ST_PRESENT: begin
            if_valid        = 1'b1;
            instruction_out = ibuf_q;
            if (redirect) begin
               pc_d    = redirect_pc;
               state_d = ST_REQ;
            end else if (!stall) begin
               if (is_halt) begin
                  state_d = ST_HALTED;
               end else begin
                  // Consume and issue the sequential fetch in the same cycle.
                  pc_d      = pc_plus2;
                  imem_req  = 1'b1;
                  imem_addr = pc_plus2;
                  state_d   = ST_WAIT;
               end
            end
         end
         ST_HALTED: begin
            halt_fetched = 1'b1;
            if (redirect) begin
               pc_d    = redirect_pc;
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_REQ;
      endcase

      if (rst) begin
         imem_req        = 1'b0;
         if_valid        = 1'b0;
         instruction_out = NOP_INSTR;
         halt_fetched    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_REQ;
         pc_q    <= RESET_PC;
         ibuf_q  <= NOP_INSTR;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ibuf_q  <= ibuf_d;
         kill_q  <= kill_d;
      end
   end

endmodule
